fp16_div_iter: RTL and testbench
================================

// Module: fp16_div_iter
// PURPOSE
//  Iterative IEEE-754 half-precision divider, result = a / b, with one restoring quotient bit per cycle.
//  It is the inverse-operation companion to the pipelined FP multiplier in the FP arithmetic datapath.
//  It trades throughput for area: one operation in flight, with valid/ready handshakes on both sides.
// PARAMETERS
//  EXP_W   5   exponent width
//  MAN_W   10  stored mantissa width (hidden bit is implicit)
//  BIAS    15  exponent bias
// PORTS
//  clk        in   1            clock; all state updates on the rising edge
//  rst        in   1            synchronous, active-high reset
//  in_valid   in   1            operands a and b are valid
//  in_ready   out  1            divider can accept an operation
//  a          in   1+EXP_W+MAN_W  dividend
//  b          in   1+EXP_W+MAN_W  divisor
//  out_valid  out  1            result and flags are valid
//  out_ready  in   1            consumer takes the result
//  result     out  1+EXP_W+MAN_W  quotient
//  flags      out  5            [4] invalid, [3] divbyzero, [2] overflow, [1] underflow, [0] inexact
// BEHAVIOUR
//  Reset
//  - state=IDLE; in_ready=1; out_valid=0; result=0; flags=0.
//  - rst during any state aborts the operation; the cycle after rst, in_ready=1 and out_valid=0.
//  State machine: IDLE -> PREP -> DIV -> ROUND -> DONE -> IDLE
//  - in_ready=1 only in IDLE.
//  - Accept when in_valid&&in_ready: latch a and b, go to PREP.
//  - PREP (1 cycle)
//    - Unpack; Ma={1,man}, Mb={1,man}.
//    - Any operand with E=0 is treated as zero (denormals flushed).
//    - Es = Ea-Eb+BIAS, 7-bit signed. Sign = Sa^Sb.
//    - Classify specials and load the remainder.
//  - DIV (14 cycles, counter 13..0)
//    - Restoring step: rem = rem<<1; if rem>=Mb then rem -= Mb and q bit=1.
//    - Yields 14 quotient bits with the binary point after q[13].
//    - Specials still traverse DIV: latency is fixed for every operand.
//  - ROUND (1 cycle)
//    - If q[13]=0: shift q left 1 and Es -= 1.
//    - Mantissa = q[12:3]; guard=q[2]; sticky = q[1]|q[0]|(rem!=0).
//    - Round to nearest even; a mantissa carry-out increments Es.
//    - Es>=31 -> +/-inf, overflow+inexact.
//    - Es<=0 -> +/-0, underflow+inexact.
//    - Inexact when guard|sticky.
//  - DONE
//    - out_valid=1; result and flags are held stable while !out_ready.
//    - On out_ready, go to IDLE (out_valid=0 the next cycle).
//  Latency and throughput
//  - out_valid rises 17 edges after the accepting edge.
//  - Minimum issue interval is 18 cycles (no accept in the same cycle as the output handshake).
//  Specials (precedence top-down; NaN output is always 16'h7E00)
//  - a or b NaN, 0/0, or inf/inf -> NaN, invalid.
//  - finite nonzero / 0 -> signed inf, divbyzero.
//  - inf / finite -> signed inf, no flags.
//  - 0 / nonzero, or finite / inf -> signed zero, no flags.
//  - Sign of inf and zero results = Sa^Sb.
// STRUCTURE
//  fp16_pkg holds:
//  - EXP_W, MAN_W, BIAS, QNAN=16'h7E00, POS_INF=16'h7C00
//  - flag bit index localparams
//  - state encoding for IDLE/PREP/DIV/ROUND/DONE
//  - DIV_ITERS=14 and LATENCY=17
//  One sub-module, fp16_div_round:
//  - purely combinational normalize/round/overflow/underflow stage used in ROUND.
//  - inputs q[13:0], rem_nz, Es, sign; outputs packed result and flags.
//  The FSM, counter and restoring datapath stay in fp16_div_iter.
// TESTING
//  1. a=16'h4200 (3.0), b=16'h3E00 (1.5) -> result 16'h4000, flags 0, out_valid exactly 17 edges after accept.
//  2. a=16'h3C00, b=16'h4200 -> result 16'h3555, flags 5'b00001.
//     a=16'hBC00, b=16'h4200 -> result 16'hB555.
//  3. a=16'h3C00, b=16'h0000 -> 16'h7C00, flags 5'b01000.
//     a=16'hBC00, b=16'h0000 -> 16'hFC00.
//     a=16'h0000, b=16'h0000 -> 16'h7E00, flags 5'b10000.
//     a=16'h7C00, b=16'h7C00 -> 16'h7E00, flags 5'b10000.
//  4. a=16'h7BFF, b=16'h1400 -> 16'h7C00, flags 5'b00101.
//     a=16'h0400, b=16'h4000 -> 16'h0000, flags 5'b00011.
//  5. Hold out_ready=0 for 20 cycles after out_valid -> result and flags stable, in_ready=0, and in_valid pulses are ignored.
//     Then out_ready=1 -> IDLE next cycle.
//  6. Assert rst for 1 cycle at iteration 7 of DIV -> next cycle out_valid=0, in_ready=1.
//     A following 16'h4400/16'h4000 -> 16'h4000 (4.0/2.0 = 2.0) with normal latency.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared constants and types for the half-precision iterative divider.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int DIV_ITERS = 14;
  // Edges from the accepting edge to the first edge at which out_valid is high.
  localparam int LATENCY   = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_DIV,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    SP_NONE,
    SP_NAN,
    SP_DZ,
    SP_INF,
    SP_ZERO
  } special_t;

endpackage

// File: rtl/fp16_div_round.sv
// Combinational normalize / round-to-nearest-even / range check of the raw quotient.
module fp16_div_round
  import fp16_pkg::*;
(
  input  logic              [13:0] q,
  input  logic                     rem_nz,
  input  logic signed       [6:0]  es,
  input  logic                     sign,
  output logic              [15:0] result,
  output logic              [4:0]  flags
);

  logic        [12:0] qn;
  logic signed [6:0]  esn;
  logic signed [6:0]  esr;
  logic               guard;
  logic               sticky;
  logic               rnd_up;
  logic        [10:0] sum;

  always_comb begin
    // q[13] is the integer bit; drop it once the quotient is normalized.
    qn     = q[13] ? q[12:0] : {q[11:0], 1'b0};
    esn    = q[13] ? es : es - 7'sd1;
    guard  = qn[2];
    sticky = qn[1] | qn[0] | rem_nz;
    rnd_up = guard & (sticky | qn[3]);
    sum    = {1'b0, qn[12:3]} + {10'd0, rnd_up};
    esr    = sum[10] ? esn + 7'sd1 : esn;

    result          = '0;
    flags           = '0;
    flags[FLAG_NX]  = guard | sticky;
    if (esr >= 7'sd31) begin
      result         = POS_INF | {sign, 15'd0};
      flags[FLAG_OF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else if (esr <= 7'sd0) begin
      result         = {sign, 15'd0};
      flags[FLAG_UF] = 1'b1;
      flags[FLAG_NX] = 1'b1;
    end else begin
      result = {sign, esr[4:0], sum[9:0]};
    end
  end

endmodule

// File: rtl/fp16_div_iter.sv
// Iterative half-precision divider: one restoring quotient bit per cycle, one op in flight.
module fp16_div_iter
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic [4:0]  flags
);

  state_t             state;
  special_t           special;
  logic        [15:0] op_a;
  logic        [15:0] op_b;
  logic               sign;
  logic signed [6:0]  es;
  logic        [10:0] mb;
  logic        [11:0] rem;
  logic        [13:0] q;
  logic        [3:0]  cnt;

  logic        [4:0]  ea, eb;
  logic        [9:0]  fa, fb;
  logic               za, zb, ia, ib, na, nb;
  logic signed [6:0]  es_w;
  special_t           special_w;

  always_comb begin
    ea   = op_a[14:10];
    eb   = op_b[14:10];
    fa   = op_a[9:0];
    fb   = op_b[9:0];
    za   = (ea == '0);
    zb   = (eb == '0);
    ia   = (ea == '1) && (fa == '0);
    ib   = (eb == '1) && (fb == '0);
    na   = (ea == '1) && (fa != '0);
    nb   = (eb == '1) && (fb != '0);
    es_w = {2'b00, ea} - {2'b00, eb} + 7'(BIAS);
    special_w = SP_NONE;
    if (na || nb || (za && zb) || (ia && ib))
      special_w = SP_NAN;
    else if (zb && !ia)
      special_w = SP_DZ;
    else if (ia)
      special_w = SP_INF;
    else if (za || ib)
      special_w = SP_ZERO;
  end

  // Remainder is kept at twice its true scale, so the divisor is compared as 2*Mb;
  // this makes the first quotient bit the integer bit without losing Ma's LSB.
  logic [12:0] rem_sh;
  logic [12:0] dvs;
  logic        ge;
  logic [11:0] rem_nx;

  always_comb begin
    rem_sh = {rem, 1'b0};
    dvs    = {1'b0, mb, 1'b0};
    ge     = (rem_sh >= dvs);
    rem_nx = ge ? 12'(rem_sh - dvs) : rem_sh[11:0];
  end

  logic        rem_nz;
  logic [15:0] rnd_result;
  logic [4:0]  rnd_flags;

  assign rem_nz = (rem != '0);

  fp16_div_round u_round (
    .q      (q),
    .rem_nz (rem_nz),
    .es     (es),
    .sign   (sign),
    .result (rnd_result),
    .flags  (rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      special   <= SP_NONE;
      op_a      <= '0;
      op_b      <= '0;
      sign      <= 1'b0;
      es        <= '0;
      mb        <= '0;
      rem       <= '0;
      q         <= '0;
      cnt       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= b;
            in_ready <= 1'b0;
            state    <= S_PREP;
          end
        end
        S_PREP: begin
          sign    <= op_a[15] ^ op_b[15];
          es      <= es_w;
          mb      <= {1'b1, fb};
          rem     <= {1'b0, 1'b1, fa};
          q       <= '0;
          cnt     <= 4'(DIV_ITERS - 1);
          special <= special_w;
          state   <= S_DIV;
        end
        S_DIV: begin
          q   <= {q[12:0], ge};
          rem <= rem_nx;
          if (cnt == '0)
            state <= S_ROUND;
          else
            cnt <= cnt - 4'd1;
        end
        S_ROUND: begin
          flags <= '0;
          case (special)
            SP_NAN: begin
              result         <= QNAN;
              flags[FLAG_NV] <= 1'b1;
            end
            SP_DZ: begin
              result         <= POS_INF | {sign, 15'd0};
              flags[FLAG_DZ] <= 1'b1;
            end
            SP_INF:  result <= POS_INF | {sign, 15'd0};
            SP_ZERO: result <= {sign, 15'd0};
            default: begin
              result <= rnd_result;
              flags  <= rnd_flags;
            end
          endcase
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_div_iter.sv
// Scoreboard bench for fp16_div_iter: expectations queued at issue, checked on output.
module tb_fp16_div_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned acc_cyc = 0;

  typedef struct {
    logic [15:0] res;
    logic [4:0]  fl;
    string       name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp16_div_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic [15:0] eres,
                       input logic [4:0] efl, input string nm);
    int unsigned k = 0;
    @(negedge clk);
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
    end
    sb.push_back('{eres, efl, nm});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic collect(input bit chk_lat);
    int unsigned k = 0;
    exp_t e;
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL out_valid timeout: out_valid=%b required 1", out_valid);
    end
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: output with empty queue, result=%h", result);
    end else begin
      e = sb.pop_front();
      n_tests++;
      if (result !== e.res) begin
        n_fail++;
        $display("FAIL %s result: got %h required %h", e.name, result, e.res);
      end
      n_tests++;
      if (flags !== e.fl) begin
        n_fail++;
        $display("FAIL %s flags: got %b required %b", e.name, flags, e.fl);
      end
      if (chk_lat) begin
        n_tests++;
        if (cyc + 1 - acc_cyc != 17) begin
          n_fail++;
          $display("FAIL %s latency: got %0d required 17", e.name, cyc + 1 - acc_cyc);
        end
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL return_idle: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
    n_tests++;
    if (result !== 16'h0000) begin n_fail++; $display("FAIL reset result: got %h required 0000", result); end
    n_tests++;
    if (flags !== 5'b00000) begin n_fail++; $display("FAIL reset flags: got %b required 00000", flags); end
  endtask

  task automatic test_basic;
    issue(16'h4200, 16'h3E00, 16'h4000, 5'b00000, "3.0/1.5");  collect(1'b1);
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, "1/3");      collect(1'b1);
    issue(16'hBC00, 16'h4200, 16'hB555, 5'b00001, "-1/3");     collect(1'b0);
    issue(16'hC400, 16'h4000, 16'hC000, 5'b00000, "-4/2");     collect(1'b0);
  endtask

  task automatic test_specials;
    issue(16'h3C00, 16'h0000, 16'h7C00, 5'b01000, "1/0");      collect(1'b0);
    issue(16'hBC00, 16'h0000, 16'hFC00, 5'b01000, "-1/0");     collect(1'b0);
    issue(16'h0000, 16'h0000, 16'h7E00, 5'b10000, "0/0");      collect(1'b0);
    issue(16'h7C00, 16'h7C00, 16'h7E00, 5'b10000, "inf/inf");  collect(1'b1);
    issue(16'h7E01, 16'h3C00, 16'h7E00, 5'b10000, "nan/1");    collect(1'b0);
    issue(16'h7C00, 16'hC000, 16'hFC00, 5'b00000, "inf/-2");   collect(1'b0);
    issue(16'h0000, 16'h4000, 16'h0000, 5'b00000, "0/2");      collect(1'b0);
    issue(16'h3C00, 16'hFC00, 16'h8000, 5'b00000, "1/-inf");   collect(1'b0);
  endtask

  task automatic test_range;
    issue(16'h7BFF, 16'h1400, 16'h7C00, 5'b00101, "overflow");  collect(1'b0);
    issue(16'h0400, 16'h4000, 16'h0000, 5'b00011, "underflow"); collect(1'b0);
  endtask

  task automatic test_backpressure;
    int unsigned k = 0;
    bit seen = 1'b0;
    exp_t e;
    issue(16'h4200, 16'h3E00, 16'h4000, 5'b00000, "hold");
    while (!out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    e = sb.pop_front();
    for (int i = 0; i < 20; i++) begin
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold handshake %0d: out_valid=%b in_ready=%b required 1/0", i, out_valid, in_ready);
      end
      n_tests++;
      if (result !== e.res || flags !== e.fl) begin
        n_fail++;
        $display("FAIL hold stable %0d: got %h/%b required %h/%b", i, result, flags, e.res, e.fl);
      end
      in_valid = (i % 2 == 0);
      a = 16'h4400;
      b = 16'h3C00;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL hold ignored_pulses: out_valid seen=1 required 0");
    end
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    issue(16'h3C00, 16'h4200, 16'h3555, 5'b00001, "aborted");
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL mid_reset aborted_op_completed: out_valid seen=1 required 0");
    end
    issue(16'h4400, 16'h4000, 16'h4000, 5'b00000, "4/2 after reset");
    collect(1'b1);
  endtask

  task automatic test_back_to_back;
    int unsigned k = 0;
    int unsigned first_acc;
    bit got = 1'b0;
    exp_t e;
    out_ready = 1'b1;
    issue(16'h4200, 16'h3E00, 16'h4000, 5'b00000, "b2b first");
    first_acc = acc_cyc;
    sb.push_back('{16'hC000, 5'b00000, "b2b second"});
    a = 16'hC400;
    b = 16'h4000;
    in_valid = 1'b1;
    while (k < 40 && !(got && in_ready)) begin
      if (out_valid && !got) begin
        got = 1'b1;
        e = sb.pop_front();
        n_tests++;
        if (result !== e.res || flags !== e.fl) begin
          n_fail++;
          $display("FAIL %s: got %h/%b required %h/%b", e.name, result, flags, e.res, e.fl);
        end
      end
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (!got || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b progress: got_first=%b in_ready=%b required 1/1", got, in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
    n_tests++;
    if (acc_cyc - first_acc != 18) begin
      n_fail++;
      $display("FAIL b2b interval: got %0d required 18", acc_cyc - first_acc);
    end
    collect(1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_specials();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
